// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch FSM encoding and fetch timeout.
package cpu_pkg;

    localparam int PC_W = 8;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_NAND = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1001;
    localparam logic [3:0] OP_XNOR = 4'b1010;
    localparam logic [3:0] OP_MOV  = 4'b1011;
    localparam logic [3:0] OP_MVI  = 4'b1100;
    localparam logic [3:0] OP_LDA  = 4'b1101;

    // WAIT cycles tolerated without rom_valid before flagging a timeout
    localparam logic [3:0] TIMEOUT_LIMIT = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fe_state_t;

    function automatic logic is_two_word(input logic [3:0] op);
        return (op == OP_MVI) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: parallel load, increment, and increments deferred while a fetch waits on ROM.
module pc_reg
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_wait,
    input  logic            apply_pending,
    input  logic            pc_load,
    input  logic            pc_inc,
    input  logic [PC_W-1:0] pc_din,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_val_reg;
    logic            inc_pending_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_val_reg      <= '0;
            inc_pending_reg <= 1'b0;
        end else if (pc_load) begin
            pc_val_reg      <= pc_din;
            inc_pending_reg <= 1'b0;
        end else if (in_wait) begin
            // Any number of increments requested during WAIT collapse into one
            if (pc_inc)
                inc_pending_reg <= 1'b1;
        end else begin
            if (pc_inc || (apply_pending && inc_pending_reg))
                pc_val_reg <= pc_val_reg + {{(PC_W-1){1'b0}}, 1'b1};
            if (apply_pending)
                inc_pending_reg <= 1'b0;
        end
    end

    assign pc = pc_val_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one ROM read per fetch, captures the word into ir or
// the immediate register, and flags ROM timeouts.
module instr_fetch
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            fe_ins_load,
    input  logic            fe_pc_load,
    input  logic            fe_pc_inc,
    input  logic [PC_W-1:0] pc_din,
    output logic            rom_req,
    output logic [PC_W-1:0] rom_addr,
    input  logic [15:0]     rom_data,
    input  logic            rom_valid,
    output logic [3:0]      fe_opcode,
    output logic [2:0]      fe_op1_addr,
    output logic [2:0]      fe_op2_addr,
    output logic [15:0]     fe_imm,
    output logic [PC_W-1:0] pc,
    output logic            fe_busy,
    output logic            fe_ready,
    output logic            fe_two_word,
    output logic            fe_err
);

    fe_state_t       state_reg;
    logic [15:0]     ir_reg;
    logic [15:0]     imm_reg;
    logic [PC_W-1:0] rom_addr_reg;
    logic            rom_req_reg;
    logic            busy_reg;
    logic            ready_reg;
    logic            two_word_reg;
    logic            err_reg;
    logic            fetch_end_reg;
    logic [3:0]      wait_cnt_reg;
    logic            in_wait;

    assign in_wait = (state_reg == ST_WAIT);

    pc_reg u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .in_wait       (in_wait),
        .apply_pending (fetch_end_reg),
        .pc_load       (fe_pc_load),
        .pc_inc        (fe_pc_inc),
        .pc_din        (pc_din),
        .pc            (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            ir_reg        <= '0;
            imm_reg       <= '0;
            rom_addr_reg  <= '0;
            rom_req_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            ready_reg     <= 1'b0;
            two_word_reg  <= 1'b0;
            err_reg       <= 1'b0;
            fetch_end_reg <= 1'b0;
            wait_cnt_reg  <= '0;
        end else begin
            rom_req_reg   <= 1'b0;
            ready_reg     <= 1'b0;
            fetch_end_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (fe_ins_load) begin
                        state_reg    <= ST_REQ;
                        rom_req_reg  <= 1'b1;
                        rom_addr_reg <= pc;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_REQ: begin
                    state_reg    <= ST_WAIT;
                    wait_cnt_reg <= '0;
                end
                ST_WAIT: begin
                    if (rom_valid) begin
                        // Second word of MVI/LDA goes to the immediate, ir keeps the opcode word
                        if (two_word_reg) begin
                            imm_reg      <= rom_data;
                            two_word_reg <= 1'b0;
                        end else begin
                            ir_reg       <= rom_data;
                            two_word_reg <= is_two_word(rom_data[15:12]);
                        end
                        ready_reg     <= 1'b1;
                        fetch_end_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end else if (wait_cnt_reg == TIMEOUT_LIMIT - 4'd1) begin
                        err_reg       <= 1'b1;
                        fetch_end_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        wait_cnt_reg  <= '0;
                        state_reg     <= ST_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_req     = rom_req_reg;
    assign rom_addr    = rom_addr_reg;
    assign fe_opcode   = ir_reg[15:12];
    assign fe_op1_addr = ir_reg[11:9];
    assign fe_op2_addr = ir_reg[8:6];
    assign fe_imm      = imm_reg;
    assign fe_busy     = busy_reg;
    assign fe_ready    = ready_reg;
    assign fe_two_word = two_word_reg;
    assign fe_err      = err_reg;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports fe_ins_load, fe_pc_load and fe_pc_inc, each input, 1: start a fetch, load PC from pc_din, and increment PC, respectively.
REQ-004 SHALL have port pc_din, input, 8, PC parallel-load value.
REQ-005 SHALL have ports rom_req, output, 1, one-cycle read strobe, and rom_addr, output, 8, registered fetch address.
REQ-006 SHALL have ports rom_data, input, 16, read word, and rom_valid, input, 1, rom_data valid this cycle.
REQ-007 SHALL have ports fe_opcode, output, 4, = ir[15:12]; fe_op1_addr, output, 3, = ir[11:9]; and fe_op2_addr, output, 3, = ir[8:6].
REQ-008 SHALL have ports fe_imm, output, 16, second word of a two-word instruction, and pc, output, 8, current PC.
REQ-009 SHALL have ports fe_busy, output, 1, high in REQ/WAIT; fe_ready, output, 1, one-cycle pulse on word capture; and fe_two_word, output, 1, second word pending.
REQ-010 SHALL have port fe_err, output, 1, sticky ROM-timeout flag.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, WAIT.
REQ-012 IDLE SHALL go to REQ on fe_ins_load=1 and ignore rom_valid.
REQ-013 REQ SHALL last one cycle with rom_req=1 and rom_addr=pc as sampled on the IDLE->REQ edge, then go to WAIT.
REQ-014 WAIT SHALL capture rom_data on rom_valid=1, pulse fe_ready=1 on the next cycle, and return to IDLE.
REQ-015 Capture target SHALL be ir when fe_two_word=0, or fe_imm when fe_two_word=1; the latter clears fe_two_word.
REQ-016 fe_two_word SHALL be set when a word captured into ir has opcode 4'b1100 (MVI) or 4'b1101 (LDA).
REQ-017 Fetch latency SHALL be fe_ins_load edge -> rom_req the next cycle; with rom_valid in the first WAIT cycle, fe_ready follows 3 cycles after fe_ins_load.
REQ-018 WAIT SHALL count cycles in a 4-bit counter; after 15 cycles without rom_valid it SHALL set fe_err=1, return to IDLE, and leave ir/fe_imm/fe_two_word unchanged.
REQ-019 fe_ins_load outside IDLE SHALL be ignored (no queueing).
REQ-020 PC SHALL be 8 bits and wrap from 8'hFF to 8'h00 on increment.
REQ-021 fe_pc_load SHALL take priority over fe_pc_inc in the same cycle.
REQ-022 In IDLE/REQ, fe_pc_load/fe_pc_inc SHALL apply at that edge; a fetch started the same cycle SHALL use the pre-update PC.
REQ-023 In WAIT, fe_pc_inc SHALL set an inc_pending bit, applied the cycle after capture or timeout; multiple requests SHALL collapse to a single increment.
REQ-024 In WAIT, fe_pc_load SHALL apply immediately and clear inc_pending.
REQ-025 Decoded outputs SHALL remain stable between captures.

Reset
REQ-026 On rst=1: state=IDLE; pc=0; ir=0; fe_imm=0; rom_addr=0; rom_req=0; fe_ready=0; fe_busy=0; fe_two_word=0; fe_err=0; inc_pending=0; timeout counter=0.
REQ-027 Reset during REQ/WAIT SHALL abort the fetch; a rom_valid arriving after reset SHALL be ignored.
REQ-028 rst SHALL dominate all other inputs in the same cycle.

Structure
REQ-029 Opcode constants (MVI=4'b1100, LDA=4'b1101, ADD..XNOR 4'b0000-4'b1010, MOV=4'b1011), the FSM state encoding and the timeout limit (15) SHALL live in shared package cpu_pkg.
REQ-030 The PC register with load/inc/pending logic SHALL be sub-module pc_reg; the FSM and capture logic SHALL stay in instr_fetch.

Verification
REQ-031 Reset, pc_din=8'h10 with fe_pc_load, fe_ins_load, ROM returns 16'h0A40 after 1 cycle -> rom_addr=8'h10, fe_opcode=4'h0, fe_op1_addr=5, fe_op2_addr=1, fe_ready at cycle+3, fe_two_word=0.
REQ-032 Fetch 16'hC200 at pc=3, fe_pc_inc, then fetch 16'h1234 -> fe_two_word=1 after first capture; fe_imm=16'h1234, ir unchanged, fe_two_word=0 after second.
REQ-033 pc=8'hFF, fe_pc_inc -> pc=8'h00; fe_pc_load(8'h40) and fe_pc_inc in the same cycle -> pc=8'h40.
REQ-034 ROM never returns rom_valid -> fe_err=1 after 15 WAIT cycles, state IDLE, ir unchanged; fe_err stays 1 until rst.
REQ-035 Two fe_pc_inc pulses during WAIT at pc=5 -> pc=6 exactly, one cycle after capture.
REQ-036 rst in WAIT, then rom_valid with 16'hFFFF -> ir=0, fe_ready=0, state IDLE.
